c1541_trk_arb: RTL and testbench
================================

// Module: c1541_trk_arb
// PURPOSE
//  Arbitrates one shared single-port track-buffer RAM between NDRV c1541 drive GCR engines and one host port (SD/image loader).
//  Registered 1-cycle-read RAM, same as the c1541mem style; the RAM sits outside this block.
//  Sequences each access as a fixed 3-cycle transaction: grant, access, respond.
//  Drives share the RAM round-robin; the host has priority but cannot starve drives.
// PARAMETERS
//  NDRV       4   number of drive requesters (1..8)
//  AW         13  per-drive byte address width (8KB track slot)
//  HOST_PRIO  1   1: host wins ties (with the anti-starvation rule); 0: host is treated as requester index NDRV in the round-robin
// PORTS
//  clk        in   1              system clock
//  reset      in   1              synchronous, active-high
//  drv_req    in   NDRV           level request per drive; held until ack
//  drv_we     in   NDRV           1=write, 0=read; stable while req is high
//  drv_addr   in   NDRV*AW        per-drive slot address, packed (drive i at [i*AW +: AW])
//  drv_wdata  in   NDRV*8         per-drive write data, packed
//  drv_ack    out  NDRV           one-cycle completion pulse
//  drv_rdata  out  8              read data; valid only in the drv_ack cycle
//  hst_req    in   1              host level request
//  hst_we     in   1              host write enable
//  hst_addr   in   DW+AW          host full address {slot, addr}, where DW=$clog2(NDRV) (min 1)
//  hst_wdata  in   8              host write data
//  hst_ack    out  1              one-cycle completion pulse
//  hst_rdata  out  8              read data; valid only in the hst_ack cycle
//  mem_addr   out  DW+AW          RAM address, registered
//  mem_we     out  1              RAM write strobe, registered
//  mem_wdata  out  8              RAM write data, registered
//  mem_rdata  in   8              RAM q; valid 1 cycle after mem_addr
//  gnt_id     out  4              current/last owner: 0..NDRV-1 = drive, 15 = host
//  busy       out  1              1 while the FSM is not in IDLE
// BEHAVIOUR
//  Reset values
//   - all acks 0, mem_we 0, mem_addr 0, mem_wdata 0, busy 0, gnt_id 0.
//   - rr_ptr = NDRV-1, so drive 0 is served first; host_last = 0.
//  FSM states IDLE -> ACC -> RSP -> IDLE.
//   - IDLE, cycle n: if any request is high, choose the winner, register mem_* and gnt_id, set busy, go to ACC; otherwise stay.
//   - ACC, cycle n+1: mem_addr/mem_we/mem_wdata are presented. mem_we drops at the end of ACC, so a write commits exactly once.
//   - RSP, cycle n+2: winner's ack=1 and its rdata=mem_rdata. For writes, rdata = mem_rdata (don't care). Go to IDLE.
//  Handshake and throughput
//   - Requester must drop req in the cycle after ack if done; IDLE at n+3 then sees it low.
//   - If req is still high at n+3, it is a new transaction.
//   - Throughput: 1 access per 3 clk. Minimum latency req->ack = 2 cycles.
//  Address formation
//   - Drive i: mem_addr = {i[DW-1:0], drv_addr[i]}.
//   - Host: mem_addr = hst_addr, passed through unchanged.
//  Arbitration when HOST_PRIO=1
//   - Host wins if hst_req && !(host_last && any drv_req).
//   - Otherwise pick the first drv_req at or after (rr_ptr+1) mod NDRV, with wrap-around.
//   - On a drive grant: rr_ptr <= winner, host_last <= 0. On a host grant: host_last <= 1.
//   - Result: host and drives alternate when both are pending continuously.
//  Arbitration when HOST_PRIO=0
//   - Same round-robin over NDRV+1 requesters; host is index NDRV.
//  Boundary conditions
//   - Requests arriving or changing during ACC/RSP are ignored until IDLE. The winner's req/we/addr/wdata are sampled only at the IDLE grant edge.
//   - A requester dropping req before ack still receives its ack; the transaction completes.
//   - NDRV=1: the round-robin degenerates to a single requester; DW=1 and the slot bit is 0.
//   - Reset in ACC: mem_we is cleared at the reset edge, but the RAM samples the pre-reset mem_we=1, so that write is committed. No ack is issued.
//   - Reset in RSP: the pending ack is suppressed; state goes to IDLE.
//   - Never more than one ack high in any cycle.
// STRUCTURE
//  Package c1541_trk_pkg
//   - typedef enum logic[1:0] {IDLE,ACC,RSP} trk_state_t.
//   - localparam HOST_ID=4'hF.
//   - function rr_next(ptr,n) for the modulo-n increment.
//  Sub-module c1541_rr_pick #(N)
//   - combinational round-robin picker: req[N], ptr -> gnt_valid, gnt_idx.
//  Top: FSM, mem_* output registers, ack decode, packed-vector slicing.
// TESTING
//  1. Single read: drv_req[2]=1, addr 13'h0123, RAM[{2,0123}]=8'hA5 -> mem_addr={2,13'h0123} at n+1; drv_ack[2]=1, drv_rdata=A5 at n+2.
//  2. Round-robin: drv_req=4'b1111 held -> grant order 0,1,2,3,0,1, each 3 cycles apart; no back-to-back grants to the same drive.
//  3. Host anti-starvation: hst_req=1 and drv_req[1]=1 both held -> grant order host,1,host,1.
//  4. Write then read: host writes 8'h3C to {3,13'h1FFF} (top address), then drive 3 reads 13'h1FFF -> drv_rdata=3C, exactly one mem_we pulse.
//  5. Reset mid-op: assert reset in ACC of a drive-0 write -> RAM holds the new data, no drv_ack, all outputs 0 next cycle, drive 0 served first afterwards.
//  6. Mid-transaction change: drv_addr changes during ACC -> mem_addr unchanged. Req dropped in ACC -> ack still issued at RSP.

Source files
------------

// File: rtl/c1541_trk_pkg.sv
// rtl/c1541_trk_pkg.sv - shared types, constants and helpers for the c1541 track-buffer arbiter
package c1541_trk_pkg;

    typedef enum logic [1:0] {IDLE, ACC, RSP} trk_state_t;

    localparam logic [3:0] HOST_ID = 4'hF;

    function automatic logic [3:0] rr_next(input logic [3:0] ptr, input int n);
        return (int'(ptr) + 1 >= n) ? 4'd0 : ptr + 4'd1;
    endfunction

endpackage

// File: rtl/c1541_trk_arb_if.sv
// rtl/c1541_trk_arb_if.sv - drive, host and RAM signal bundle for the track-buffer arbiter
interface c1541_trk_arb_if #(
    parameter int NDRV = 4,
    parameter int AW   = 13
);
    localparam int DW = (NDRV > 1) ? $clog2(NDRV) : 1;

    logic [NDRV-1:0]      drv_req;
    logic [NDRV-1:0]      drv_we;
    logic [NDRV*AW-1:0]   drv_addr;
    logic [NDRV*8-1:0]    drv_wdata;
    logic [NDRV-1:0]      drv_ack;
    logic [7:0]           drv_rdata;
    logic                 hst_req;
    logic                 hst_we;
    logic [DW+AW-1:0]     hst_addr;
    logic [7:0]           hst_wdata;
    logic                 hst_ack;
    logic [7:0]           hst_rdata;
    logic [DW+AW-1:0]     mem_addr;
    logic                 mem_we;
    logic [7:0]           mem_wdata;
    logic [7:0]           mem_rdata;
    logic [3:0]           gnt_id;
    logic                 busy;

    modport slave (
        input  drv_req, drv_we, drv_addr, drv_wdata,
        input  hst_req, hst_we, hst_addr, hst_wdata,
        input  mem_rdata,
        output drv_ack, drv_rdata, hst_ack, hst_rdata,
        output mem_addr, mem_we, mem_wdata, gnt_id, busy
    );

    modport master (
        output drv_req, drv_we, drv_addr, drv_wdata,
        output hst_req, hst_we, hst_addr, hst_wdata,
        output mem_rdata,
        input  drv_ack, drv_rdata, hst_ack, hst_rdata,
        input  mem_addr, mem_we, mem_wdata, gnt_id, busy
    );

endinterface

// File: rtl/c1541_rr_pick.sv
// rtl/c1541_rr_pick.sv - combinational round-robin picker starting one past the last winner
module c1541_rr_pick
    import c1541_trk_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] i_req,
    input  logic [3:0]   i_ptr,
    output logic         o_gnt_valid,
    output logic [3:0]   o_gnt_idx
);

    logic [15:0] w_req;
    logic [3:0]  w_idx;

    assign w_req = 16'(i_req);

    always_comb begin
        o_gnt_valid = 1'b0;
        o_gnt_idx   = '0;
        w_idx       = rr_next(i_ptr, N);
        for (int k = 0; k < N; k++) begin
            if (!o_gnt_valid && w_req[w_idx]) begin
                o_gnt_valid = 1'b1;
                o_gnt_idx   = w_idx;
            end
            w_idx = rr_next(w_idx, N);
        end
    end

endmodule

// File: rtl/c1541_trk_arb.sv
// rtl/c1541_trk_arb.sv - 3-cycle grant/access/respond arbiter sharing one track RAM among drives and host
module c1541_trk_arb
    import c1541_trk_pkg::*;
#(
    parameter int NDRV      = 4,
    parameter int AW        = 13,
    parameter int HOST_PRIO = 1
) (
    input  logic               clk,
    input  logic               reset,
    c1541_trk_arb_if.slave     bus
);

    localparam int DW = (NDRV > 1) ? $clog2(NDRV) : 1;
    localparam int NP = (HOST_PRIO != 0) ? NDRV : NDRV + 1;

    trk_state_t         r_state;
    logic [DW+AW-1:0]   r_mem_addr;
    logic               r_mem_we;
    logic [7:0]         r_mem_wdata;
    logic [3:0]         r_gnt_id;
    logic [3:0]         r_rr_ptr;
    logic               r_busy;
    logic               r_host_last;
    logic [NDRV-1:0]    r_drv_ack;
    logic               r_hst_ack;

    logic [NP-1:0]      w_pick_req;
    logic               w_pick_valid;
    logic [3:0]         w_pick_idx;
    logic               w_host_win;
    logic               w_drv_win;
    logic [DW+AW-1:0]   w_drv_addr;
    logic               w_drv_we;
    logic [7:0]         w_drv_wdata;

    // With priority the host only yields right after its own grant, so it alternates with drives.
    generate
        if (HOST_PRIO != 0) begin : g_host_prio
            assign w_pick_req = bus.drv_req;
            assign w_host_win = bus.hst_req && !(r_host_last && (|bus.drv_req));
        end else begin : g_host_rr
            assign w_pick_req = {bus.hst_req, bus.drv_req};
            assign w_host_win = w_pick_valid && (w_pick_idx == 4'(NDRV));
        end
    endgenerate

    assign w_drv_win = w_pick_valid && !w_host_win;

    c1541_rr_pick #(.N(NP)) u_pick (
        .i_req       (w_pick_req),
        .i_ptr       (r_rr_ptr),
        .o_gnt_valid (w_pick_valid),
        .o_gnt_idx   (w_pick_idx)
    );

    always_comb begin
        w_drv_addr  = '0;
        w_drv_we    = 1'b0;
        w_drv_wdata = '0;
        for (int i = 0; i < NDRV; i++) begin
            if (w_pick_idx == 4'(i)) begin
                w_drv_addr  = {DW'(i), bus.drv_addr[i*AW +: AW]};
                w_drv_we    = bus.drv_we[i];
                w_drv_wdata = bus.drv_wdata[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_gnt_id    <= '0;
            r_rr_ptr    <= 4'(NDRV - 1);
            r_busy      <= 1'b0;
            r_host_last <= 1'b0;
            r_drv_ack   <= '0;
            r_hst_ack   <= 1'b0;
        end else begin
            r_drv_ack <= '0;
            r_hst_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_host_win) begin
                        r_mem_addr  <= bus.hst_addr;
                        r_mem_we    <= bus.hst_we;
                        r_mem_wdata <= bus.hst_wdata;
                        r_gnt_id    <= HOST_ID;
                        r_host_last <= 1'b1;
                        if (HOST_PRIO == 0)
                            r_rr_ptr <= 4'(NDRV);
                        r_busy      <= 1'b1;
                        r_state     <= ACC;
                    end else if (w_drv_win) begin
                        r_mem_addr  <= w_drv_addr;
                        r_mem_we    <= w_drv_we;
                        r_mem_wdata <= w_drv_wdata;
                        r_gnt_id    <= w_pick_idx;
                        r_rr_ptr    <= w_pick_idx;
                        r_host_last <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ACC;
                    end
                end
                ACC: begin
                    // Write strobe lasts exactly the ACC cycle; ack lands with the RAM read data.
                    r_mem_we <= 1'b0;
                    if (r_gnt_id == HOST_ID)
                        r_hst_ack <= 1'b1;
                    else
                        for (int i = 0; i < NDRV; i++)
                            r_drv_ack[i] <= (r_gnt_id == 4'(i));
                    r_state <= RSP;
                end
                RSP: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.gnt_id    = r_gnt_id;
    assign bus.busy      = r_busy;
    assign bus.drv_ack   = r_drv_ack;
    assign bus.hst_ack   = r_hst_ack;
    assign bus.drv_rdata = bus.mem_rdata;
    assign bus.hst_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_c1541_trk_arb.sv
// tb/tb_c1541_trk_arb.sv - scoreboard bench for the c1541 track-buffer arbiter
module tb_c1541_trk_arb;
    import c1541_trk_pkg::*;

    localparam int NDRV = 4;
    localparam int AW   = 13;
    localparam int DW   = 2;
    localparam int MAW  = DW + AW;

    typedef struct {
        logic [3:0] id;
        logic [7:0] data;
        logic       chk;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    c1541_trk_arb_if #(.NDRV(NDRV), .AW(AW)) bus ();

    c1541_trk_arb #(.NDRV(NDRV), .AW(AW), .HOST_PRIO(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] ram [0:(1<<MAW)-1];
    int we_pulses = 0;
    always @(posedge clk) begin
        if (bus.mem_we) begin
            ram[bus.mem_addr] <= bus.mem_wdata;
            we_pulses         <= we_pulses + 1;
        end
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    int   errors = 0;
    int   checks = 0;
    int   acks_seen = 0;
    int   cyc = 0;
    exp_t sb[$];
    int   ack_cyc[$];
    int         mon_n;
    logic [3:0] mon_id;
    logic [7:0] mon_d;
    exp_t       mon_e;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (!reset && (bus.hst_ack || (|bus.drv_ack))) begin
            mon_n  = $countones(bus.drv_ack) + int'(bus.hst_ack);
            mon_id = HOST_ID;
            mon_d  = bus.hst_rdata;
            for (int i = 0; i < NDRV; i++)
                if (bus.drv_ack[i]) begin
                    mon_id = 4'(i);
                    mon_d  = bus.drv_rdata;
                end
            checks++;
            if (mon_n != 1) begin
                errors++;
                $display("FAIL one_hot_ack: %0d acks high, expected 1", mon_n);
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: id=%0d, expected no ack", mon_id);
            end else begin
                mon_e = sb.pop_front();
                if (mon_id !== mon_e.id || (mon_e.chk && mon_d !== mon_e.data)) begin
                    errors++;
                    $display("FAIL ack_scoreboard: id=%0d data=%02h, expected id=%0d data=%02h",
                             mon_id, mon_d, mon_e.id, mon_e.data);
                end
            end
            ack_cyc.push_back(cyc);
            acks_seen++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] id, input logic [7:0] d, input logic chk);
        exp_t e;
        e.id = id; e.data = d; e.chk = chk;
        sb.push_back(e);
    endtask

    task automatic set_drv(input int i, input logic req, input logic we,
                           input logic [AW-1:0] addr, input logic [7:0] wd);
        bus.drv_req[i]            = req;
        bus.drv_we[i]             = we;
        bus.drv_addr[i*AW +: AW]  = addr;
        bus.drv_wdata[i*8 +: 8]   = wd;
    endtask

    task automatic wait_acks(input int target, input int budget);
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #1;
            if (acks_seen >= target) break;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        checks++; if (bus.mem_addr !== '0) begin errors++; $display("FAIL rst_mem_addr: got %h expected 0", bus.mem_addr); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b expected 0", bus.mem_we); end
        checks++; if (bus.mem_wdata !== 8'h00) begin errors++; $display("FAIL rst_mem_wdata: got %h expected 0", bus.mem_wdata); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.gnt_id !== 4'd0) begin errors++; $display("FAIL rst_gnt_id: got %0d expected 0", bus.gnt_id); end
        checks++; if ({bus.drv_ack, bus.hst_ack} !== 5'b0) begin errors++; $display("FAIL rst_acks: got %b expected 0", {bus.drv_ack, bus.hst_ack}); end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_write_read();
        int base, we0;
        base = acks_seen; we0 = we_pulses;
        bus.hst_req = 1'b1; bus.hst_we = 1'b1; bus.hst_addr = {2'd3, 13'h1FFF}; bus.hst_wdata = 8'h3C;
        push(HOST_ID, 8'h00, 1'b0);
        wait_acks(base + 1, 20);
        bus.hst_req = 1'b0; bus.hst_we = 1'b0;
        set_drv(3, 1'b1, 1'b0, 13'h1FFF, 8'h00);
        push(4'd3, 8'h3C, 1'b1);
        wait_acks(base + 2, 20);
        set_drv(3, 1'b0, 1'b0, 13'h0000, 8'h00);
        checks++; if (acks_seen !== base + 2) begin errors++; $display("FAIL wr_rd_acks: got %0d expected %0d", acks_seen - base, 2); end
        checks++; if (we_pulses - we0 !== 1) begin errors++; $display("FAIL wr_rd_we_pulses: got %0d expected 1", we_pulses - we0); end
    endtask

    task automatic test_single_read();
        int base;
        base = acks_seen;
        bus.hst_req = 1'b1; bus.hst_we = 1'b1; bus.hst_addr = {2'd2, 13'h0123}; bus.hst_wdata = 8'hA5;
        push(HOST_ID, 8'h00, 1'b0);
        wait_acks(base + 1, 20);
        bus.hst_req = 1'b0; bus.hst_we = 1'b0;
        set_drv(2, 1'b1, 1'b0, 13'h0123, 8'h00);
        push(4'd2, 8'hA5, 1'b1);
        tick(1);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rd_busy: got %b expected 1", bus.busy); end
        checks++; if (bus.mem_addr !== {2'd2, 13'h0123}) begin errors++; $display("FAIL rd_mem_addr: got %h expected %h", bus.mem_addr, {2'd2, 13'h0123}); end
        checks++; if (bus.gnt_id !== 4'd2) begin errors++; $display("FAIL rd_gnt_id: got %0d expected 2", bus.gnt_id); end
        tick(1);
        checks++; if (bus.drv_ack !== 4'b0100) begin errors++; $display("FAIL rd_ack: got %b expected 0100", bus.drv_ack); end
        checks++; if (bus.drv_rdata !== 8'hA5) begin errors++; $display("FAIL rd_data: got %h expected a5", bus.drv_rdata); end
        tick(1);
        set_drv(2, 1'b0, 1'b0, 13'h0000, 8'h00);
        checks++; if (acks_seen !== base + 2) begin errors++; $display("FAIL rd_acks: got %0d expected 2", acks_seen - base); end
    endtask

    task automatic test_round_robin();
        int base;
        do_reset();
        base = acks_seen;
        for (int i = 0; i < NDRV; i++) set_drv(i, 1'b1, 1'b0, 13'(i * 16), 8'h00);
        for (int k = 0; k < 6; k++) push(4'(k % NDRV), 8'h00, 1'b0);
        wait_acks(base + 6, 40);
        for (int i = 0; i < NDRV; i++) set_drv(i, 1'b0, 1'b0, 13'h0000, 8'h00);
        checks++; if (acks_seen !== base + 6) begin errors++; $display("FAIL rr_acks: got %0d expected 6", acks_seen - base); end
        checks++;
        if (ack_cyc.size() < 6 || ack_cyc[$] - ack_cyc[$-5] != 15) begin
            errors++;
            $display("FAIL rr_spacing: got %0d cycles for 5 gaps expected 15", ack_cyc.size() < 6 ? -1 : ack_cyc[$] - ack_cyc[$-5]);
        end
    endtask

    task automatic test_host_starve();
        int base;
        do_reset();
        base = acks_seen;
        bus.hst_req = 1'b1; bus.hst_we = 1'b0; bus.hst_addr = {2'd3, 13'h1FFF};
        set_drv(1, 1'b1, 1'b0, 13'h0123, 8'h00);
        push(HOST_ID, 8'h3C, 1'b1); push(4'd1, 8'h00, 1'b0);
        push(HOST_ID, 8'h3C, 1'b1); push(4'd1, 8'h00, 1'b0);
        wait_acks(base + 4, 40);
        bus.hst_req = 1'b0;
        set_drv(1, 1'b0, 1'b0, 13'h0000, 8'h00);
        checks++; if (acks_seen !== base + 4) begin errors++; $display("FAIL starve_acks: got %0d expected 4", acks_seen - base); end
    endtask

    task automatic test_mid_change();
        int base, we0;
        base = acks_seen; we0 = we_pulses;
        set_drv(0, 1'b1, 1'b1, 13'h0AAA, 8'h77);
        push(4'd0, 8'h00, 1'b0);
        tick(1);
        set_drv(0, 1'b0, 1'b1, 13'h0555, 8'h11);
        checks++; if (bus.mem_addr !== {2'd0, 13'h0AAA}) begin errors++; $display("FAIL mid_addr_acc: got %h expected %h", bus.mem_addr, {2'd0, 13'h0AAA}); end
        checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL mid_we_acc: got %b expected 1", bus.mem_we); end
        checks++; if (bus.mem_wdata !== 8'h77) begin errors++; $display("FAIL mid_wdata_acc: got %h expected 77", bus.mem_wdata); end
        tick(1);
        checks++; if (bus.drv_ack !== 4'b0001) begin errors++; $display("FAIL mid_ack: got %b expected 0001", bus.drv_ack); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL mid_we_rsp: got %b expected 0", bus.mem_we); end
        tick(2);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_no_regrant: got busy %b expected 0", bus.busy); end
        set_drv(0, 1'b1, 1'b0, 13'h0AAA, 8'h00);
        push(4'd0, 8'h77, 1'b1);
        wait_acks(base + 2, 20);
        set_drv(0, 1'b0, 1'b0, 13'h0000, 8'h00);
        checks++; if (acks_seen !== base + 2) begin errors++; $display("FAIL mid_acks: got %0d expected 2", acks_seen - base); end
        checks++; if (we_pulses - we0 !== 1) begin errors++; $display("FAIL mid_we_pulses: got %0d expected 1", we_pulses - we0); end
    endtask

    task automatic test_reset_mid();
        int base, we0;
        base = acks_seen; we0 = we_pulses;
        set_drv(0, 1'b1, 1'b1, 13'h0042, 8'h5A);
        tick(1);
        checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL rm_we_acc: got %b expected 1", bus.mem_we); end
        reset = 1'b1;
        set_drv(0, 1'b0, 1'b0, 13'h0042, 8'h00);
        tick(1);
        reset = 1'b0;
        checks++; if (bus.mem_addr !== '0 || bus.mem_we !== 1'b0 || bus.mem_wdata !== 8'h00)
            begin errors++; $display("FAIL rm_mem_cleared: got addr=%h we=%b wd=%h expected 0", bus.mem_addr, bus.mem_we, bus.mem_wdata); end
        checks++; if (bus.busy !== 1'b0 || bus.gnt_id !== 4'd0)
            begin errors++; $display("FAIL rm_state_cleared: got busy=%b gnt=%0d expected 0", bus.busy, bus.gnt_id); end
        checks++; if ({bus.drv_ack, bus.hst_ack} !== 5'b0) begin errors++; $display("FAIL rm_acks: got %b expected 0", {bus.drv_ack, bus.hst_ack}); end
        tick(3);
        checks++; if (acks_seen !== base) begin errors++; $display("FAIL rm_no_ack: got %0d acks expected 0", acks_seen - base); end
        checks++; if (we_pulses - we0 !== 1) begin errors++; $display("FAIL rm_write_commit: got %0d expected 1", we_pulses - we0); end
        set_drv(0, 1'b1, 1'b0, 13'h0042, 8'h00);
        set_drv(3, 1'b1, 1'b0, 13'h1FFF, 8'h00);
        push(4'd0, 8'h5A, 1'b1);
        push(4'd3, 8'h3C, 1'b1);
        wait_acks(base + 2, 20);
        set_drv(0, 1'b0, 1'b0, 13'h0000, 8'h00);
        set_drv(3, 1'b0, 1'b0, 13'h0000, 8'h00);
        checks++; if (acks_seen !== base + 2) begin errors++; $display("FAIL rm_after_acks: got %0d expected 2", acks_seen - base); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.drv_req = '0; bus.drv_we = '0; bus.drv_addr = '0; bus.drv_wdata = '0;
        bus.hst_req = 1'b0; bus.hst_we = 1'b0; bus.hst_addr = '0; bus.hst_wdata = '0;
        test_reset();
        test_write_read();
        test_single_read();
        test_round_robin();
        test_host_starve();
        test_mid_change();
        test_reset_mid();
        tick(2);
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL sb_drained: got %0d pending expected 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
